// File: rtl/diff_freq_serial_in.sv
// rtl/diff_freq_serial_in.sv - variable-frequency serial capture, LSB first, mid-period sampling
// Optional DIFF_FREQ_SERIAL_IN_SYNC_EN adds two-flop synchronizers on i_start and i_serial_in.
module diff_freq_serial_in #(
  parameter int DATA_BIT        = 32,
  parameter int LOW_PERIOD_CLK  = 9,
  parameter int HIGH_PERIOD_CLK = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic                i_serial_in,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_bit_tick,
  output logic                o_done_tick,
  output logic                o_busy
);

  localparam int MAX_P = (LOW_PERIOD_CLK > HIGH_PERIOD_CLK) ? LOW_PERIOD_CLK : HIGH_PERIOD_CLK;
  localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int KW    = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

  localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_PERIOD_CLK - 1);
  localparam logic [CW-1:0] LOW_MID   = CW'(LOW_PERIOD_CLK / 2);
  localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_PERIOD_CLK - 1);
  localparam logic [CW-1:0] HIGH_MID  = CW'(HIGH_PERIOD_CLK / 2);
  localparam logic [KW-1:0] K_LAST    = KW'(DATA_BIT - 1);

  typedef enum logic {S_IDLE, S_DATA} state_t;

  logic start_in;
  logic line_in;

`ifdef DIFF_FREQ_SERIAL_IN_SYNC_EN
  logic [1:0] start_sync;
  logic [1:0] line_sync;

  // Both paths get the same two-cycle delay so sampling stays centred on the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_sync <= 2'b00;
      line_sync  <= 2'b00;
    end else begin
      start_sync <= {start_sync[0], i_start};
      line_sync  <= {line_sync[0], i_serial_in};
    end
  end

  assign start_in = start_sync[1];
  assign line_in  = line_sync[1];
`else
  assign start_in = i_start;
  assign line_in  = i_serial_in;
`endif

  state_t              state, state_n;
  logic [DATA_BIT-1:0] freq_q;
  logic                mode_q;
  logic [KW-1:0]       k, k_n;
  logic [CW-1:0]       c, c_n;
  logic [DATA_BIT-1:0] shift, shift_next;
  logic                latch;
  logic                done_n;
  logic                at_mid;
  logic                at_last;

  always_comb begin
    at_mid  = 1'b0;
    at_last = 1'b0;
    if (freq_q[k]) begin
      at_mid  = (c == HIGH_MID);
      at_last = (c == HIGH_LAST);
    end else begin
      at_mid  = (c == LOW_MID);
      at_last = (c == LOW_LAST);
    end
  end

  // The sample taken in the final cycle (period of one) must reach o_data too.
  always_comb begin
    shift_next = shift;
    if (state == S_DATA && at_mid) shift_next[k] = line_in;
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    c_n     = c;
    latch   = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_in && !i_stop) begin
          state_n = S_DATA;
          k_n     = '0;
          c_n     = '0;
          latch   = 1'b1;
        end
      end
      S_DATA: begin
        if (i_stop) begin
          state_n = S_IDLE;
          k_n     = '0;
          c_n     = '0;
        end else if (at_last) begin
          c_n = '0;
          if (k == K_LAST) begin
            k_n    = '0;
            done_n = 1'b1;
            if (!mode_q) state_n = S_IDLE;
          end else begin
            k_n = k + KW'(1);
          end
        end else begin
          c_n = c + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      freq_q      <= '0;
      mode_q      <= 1'b0;
      k           <= '0;
      c           <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_done_tick <= 1'b0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      c           <= c_n;
      o_done_tick <= done_n;
      if (latch) begin
        freq_q <= i_freq_pattern;
        mode_q <= i_mode;
        shift  <= '0;
      end else begin
        shift <= shift_next;
      end
      if (done_n) o_data <= shift_next;
    end
  end

  assign o_bit_tick = (state == S_DATA) && at_last;
  assign o_busy     = (state == S_DATA);

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// tb/tb_diff_freq_serial_in.sv - directed checks of diff_freq_serial_in frame timing and capture
module tb_diff_freq_serial_in;

`ifdef DIFF_FREQ_SERIAL_IN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_mode = 1'b0;
  logic [31:0] i_freq_pattern = '0;
  logic        i_serial_in = 1'b0;
  logic [31:0] o_data;
  logic        o_bit_tick;
  logic        o_done_tick;
  logic        o_busy;

  diff_freq_serial_in dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_mode        (i_mode),
    .i_freq_pattern(i_freq_pattern),
    .i_serial_in   (i_serial_in),
    .o_data        (o_data),
    .o_bit_tick    (o_bit_tick),
    .o_done_tick   (o_done_tick),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  int          nt;
  int          nd;
  int          tick_at[64];
  int          done_at[4];
  logic [31:0] data_at[4];
  logic        busy_tr[512];
  logic [31:0] last_data;
  logic [31:0] snap_data;
  logic        snap_busy;
  logic        snap_tick;
  logic        snap_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic line_at(input int i, input logic [31:0] d0, input logic [31:0] d1,
                                   input logic [31:0] freq);
    int          len;
    int          pos;
    int          f;
    logic [31:0] d;
    if (i < 1) return 1'b0;
    len = 0;
    for (int b = 0; b < 32; b++) len += freq[b] ? 3 : 9;
    f   = (i - 1) / len;
    pos = (i - 1) % len;
    d   = (f == 0) ? d0 : ((f == 1) ? d1 : 32'h0);
    for (int b = 0; b < 32; b++) begin
      if (pos < (freq[b] ? 3 : 9)) return d[b];
      pos -= freq[b] ? 3 : 9;
    end
    return 1'b0;
  endfunction

  // Iteration i observes cycle T+i (start pulse driven at i == 0) and drives that cycle's inputs.
  task automatic run(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] freq,
                     input logic mode, input int stop_at, input int rst_at, input int start2_at,
                     input int snap_at, input int ncyc);
    nt = 0;
    nd = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (o_bit_tick && nt < 64) begin
        tick_at[nt] = i;
        nt++;
      end
      if (o_done_tick) begin
        if (nd < 4) begin
          done_at[nd] = i;
          data_at[nd] = o_data;
        end
        nd++;
      end
      if (i < 512) busy_tr[i] = o_busy;
      if (i == snap_at) begin
        snap_data = o_data;
        snap_busy = o_busy;
        snap_tick = o_bit_tick;
        snap_done = o_done_tick;
      end
      last_data      = o_data;
      i_start        = (i == 0) || (i == start2_at);
      i_stop         = (i == stop_at);
      rst_n          = (i != rst_at);
      i_mode         = (i == 0) ? mode : ~mode;
      i_freq_pattern = (i == 0) ? freq : ~freq;
      i_serial_in    = line_at(i, d0, d1, freq);
    end
    @(negedge clk);
    i_start     = 1'b0;
    i_stop      = 1'b1;
    rst_n       = 1'b1;
    i_serial_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_stop = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_data", o_data, 32'h0);
    check_eq("reset_busy", {31'h0, o_busy}, 32'h0);
    check_eq("reset_done", {31'h0, o_done_tick}, 32'h0);
    check_eq("reset_tick", {31'h0, o_bit_tick}, 32'h0);

    // Slow one-shot frame, 9 clocks per bit
    run(32'hA5A5A5A5, 32'h0, 32'h0, 1'b0, -1, -1, -1, -1, 295);
    check_eq("slow_ticks", nt, 32);
    check_eq("slow_done_cnt", nd, 1);
    check_eq("slow_done_at", done_at[0], 289 + LAT);
    check_eq("slow_data", data_at[0], 32'hA5A5A5A5);
    check_eq("slow_first_tick", tick_at[0], 9 + LAT);
    check_eq("slow_busy_after", {31'h0, busy_tr[290 + LAT]}, 32'h0);

    // Fast one-shot frame, 3 clocks per bit
    run(32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b0, -1, -1, -1, -1, 103);
    check_eq("fast_ticks", nt, 32);
    check_eq("fast_done_at", done_at[0], 97 + LAT);
    check_eq("fast_data", data_at[0], 32'h12345678);

    // Mixed periods: low half fast, high half slow
    run(32'hDEADBEEF, 32'h0, 32'h0000FFFF, 1'b0, -1, -1, -1, -1, 200);
    check_eq("mix_done_at", done_at[0], 193 + LAT);
    check_eq("mix_data", data_at[0], 32'hDEADBEEF);
    check_eq("mix_first_tick", tick_at[0], 3 + LAT);
    check_eq("mix_gap_fast", tick_at[15] - tick_at[14], 3);
    check_eq("mix_gap_slow", tick_at[16] - tick_at[15], 9);

    // Repeat mode, two back-to-back frames
    run(32'h11111111, 32'h22222222, 32'hFFFFFFFF, 1'b1, -1, -1, -1, -1, 200);
    check_eq("rep_done_cnt", nd, 2);
    check_eq("rep_done0_at", done_at[0], 97 + LAT);
    check_eq("rep_data0", data_at[0], 32'h11111111);
    check_eq("rep_done1_at", done_at[1], 193 + LAT);
    check_eq("rep_data1", data_at[1], 32'h22222222);

    // Repeat mode aborted by i_stop in the second frame
    run(32'h11111111, 32'h22222222, 32'hFFFFFFFF, 1'b1, 150, -1, -1, -1, 220);
    check_eq("stop_done_cnt", nd, 1);
    check_eq("stop_busy_150", {31'h0, busy_tr[150]}, 32'h1);
    check_eq("stop_busy_151", {31'h0, busy_tr[151]}, 32'h0);
    check_eq("stop_data_kept", last_data, 32'h11111111);

    // Mid-frame reset
    run(32'h5A5A5A5A, 32'h0, 32'h0, 1'b0, -1, 50, -1, 51, 300);
    check_eq("rst_snap_data", snap_data, 32'h0);
    check_eq("rst_snap_busy", {31'h0, snap_busy}, 32'h0);
    check_eq("rst_snap_tick", {31'h0, snap_tick}, 32'h0);
    check_eq("rst_snap_done", {31'h0, snap_done}, 32'h0);
    check_eq("rst_no_done", nd, 0);

    run(32'h0F0F1234, 32'h0, 32'h0, 1'b0, -1, -1, -1, -1, 295);
    check_eq("after_rst_done_at", done_at[0], 289 + LAT);
    check_eq("after_rst_data", data_at[0], 32'h0F0F1234);

    // Second start during a capture is ignored
    run(32'hC3C30FF0, 32'h0, 32'h0, 1'b0, -1, -1, 20, -1, 310);
    check_eq("restart_done_cnt", nd, 1);
    check_eq("restart_done_at", done_at[0], 289 + LAT);
    check_eq("restart_data", data_at[0], 32'hC3C30FF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
